// File: rtl/adder_op_sequencer.sv
// Front-end controller for the 4-bit adder lab: debounces buttons, captures operands A/B
// from the switches and alternates the LED view between the adder sum and its flags.
module adder_op_sequencer #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DISPLAY_CYCLES  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   btn,
  input  logic [W-1:0] sw,
  input  logic [W-1:0] sum,
  input  logic         carryout,
  input  logic         overflow,
  output logic [W-1:0] opA,
  output logic [W-1:0] opB,
  output logic [W-1:0] led,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    WAIT_A     = 2'd0,
    WAIT_B     = 2'd1,
    SHOW_SUM   = 2'd2,
    SHOW_FLAGS = 2'd3
  } state_t;

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DTW = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DTW-1:0] DT_LAST = DTW'((DISPLAY_CYCLES > 0) ? DISPLAY_CYCLES - 1 : 0);
  localparam bit AUTO_TOGGLE = (DISPLAY_CYCLES > 0);

  logic [3:0]     db;
  logic [3:0]     db_d;
  logic [DBW-1:0] db_cnt [4];
  logic [3:0]     press;

  state_t         cur_state;
  logic [DTW-1:0] timer;
  logic           show;

  // Each button must disagree with its debounced level for DEBOUNCE_CYCLES
  // consecutive samples before the level flips; any agreeing sample restarts the count.
  // NOTE: all sequential state uses non-blocking assignments so every read in the
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 4; i++) begin
        if (btn[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = db & ~db_d;
  assign show  = cur_state[1];
  assign state = cur_state;

  // One press per cycle is acted on: load A > load B > flags > sum; a press beats the auto-toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= WAIT_A;
      opA       <= '0;
      opB       <= '0;
      led       <= '0;
      timer     <= '0;
    end else begin
      unique case (cur_state)
        WAIT_A, WAIT_B: led <= sw;
        SHOW_SUM:       led <= sum;
        SHOW_FLAGS:     led <= W'({overflow, carryout});
      endcase

      if (press[0]) begin
        opA       <= sw;
        cur_state <= WAIT_B;
        timer     <= '0;
      end else if (press[1] && cur_state != WAIT_A) begin
        opB       <= sw;
        cur_state <= SHOW_SUM;
        timer     <= '0;
      end else if (press[3] && show) begin
        cur_state <= SHOW_FLAGS;
        timer     <= '0;
      end else if (press[2] && show) begin
        cur_state <= SHOW_SUM;
        timer     <= '0;
      end else if (show && AUTO_TOGGLE) begin
        if (timer == DT_LAST) begin
          timer     <= '0;
          cur_state <= (cur_state == SHOW_SUM) ? SHOW_FLAGS : SHOW_SUM;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule
